// File: rtl/counter_pkg.sv
// Shared constants and helpers for the parametrised counter family.
// Direction/mode encodings plus the load clamp used by param_counter.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Loads above the legal range land on the top value rather than wrapping.
  function automatic logic [63:0] clamp(input logic [63:0] value,
                                        input logic [63:0] max);
    clamp = (value > max) ? max : value;
  endfunction

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: emits one step pulse every PRESCALE enabled cycles.
// A clear (clr or load at the top) restarts the phase at zero.
module counter_prescaler
  import counter_pkg::*;
#(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic step
);

  localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] pre;

  // step is combinational so the count moves on the same edge pre wraps.
  assign step = en && !clr && (pre == LAST);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre <= '0;
    end else if (clr) begin
      pre <= '0;
    end else if (en) begin
      if (pre == LAST) pre <= '0;
      else             pre <= pre + 1'b1;
    end
  end

endmodule

// File: rtl/param_counter.sv
// Parametrised event/timer counter: modulo limit, up/down, load/clear,
// prescaled enable, wrap or saturate, terminal-count pulse, sticky ovf.
module param_counter
  import counter_pkg::*;
#(
  parameter int              WIDTH     = 4,
  parameter longint unsigned MAX_COUNT = (64'd1 << WIDTH) - 64'd1,
  parameter int              PRESCALE  = 1,
  parameter int              SATURATE  = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("param_counter: WIDTH out of range 1..32");
  end
  if (MAX_COUNT < 1 || MAX_COUNT > ((64'd1 << WIDTH) - 64'd1)) begin : g_bad_max
    $error("param_counter: MAX_COUNT out of range 1..2**WIDTH-1");
  end
  if (PRESCALE < 1 || PRESCALE > 65536) begin : g_bad_pre
    $error("param_counter: PRESCALE out of range 1..65536");
  end
  if (SATURATE != MODE_WRAP && SATURATE != MODE_SAT) begin : g_bad_sat
    $error("param_counter: SATURATE must be 0 or 1");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_COUNT);
  localparam logic             SAT   = (SATURATE == MODE_SAT);

  logic             step;
  logic [WIDTH-1:0] load_clamped;

  assign load_clamped = WIDTH'(clamp(64'(load_val), 64'(MAX_COUNT)));

  counter_prescaler #(
    .PRESCALE(PRESCALE)
  ) u_prescaler (
    .clk (clk),
    .rst (rst),
    .clr (clr | load),
    .en  (en),
    .step(step)
  );

  // Boundaries compare against MAX_C, never natural 2**WIDTH rollover.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (clr) begin
      count <= '0;
      tc    <= 1'b0;
      ovf   <= 1'b0;
    end else if (load) begin
      count <= load_clamped;
      tc    <= 1'b0;
    end else if (step) begin
      if (up == DIR_UP) begin
        if (count == MAX_C) begin
          count <= SAT ? MAX_C : '0;
          tc    <= 1'b1;
          ovf   <= 1'b1;
        end else begin
          count <= count + 1'b1;
          tc    <= 1'b0;
        end
      end else begin
        if (count == '0) begin
          count <= SAT ? '0 : MAX_C;
          tc    <= 1'b1;
          ovf   <= 1'b1;
        end else begin
          count <= count - 1'b1;
          tc    <= 1'b0;
        end
      end
    end else begin
      tc <= 1'b0;
    end
  end

endmodule

// File: tb/tb_param_counter.sv
// Directed bench for param_counter: four parameterisations share clk/rst,
// expected {count,tc,ovf} tuples are queued per step and checked after the edge.
module tb_param_counter;

  logic       clk;
  logic       rst;
  logic [3:0] clr, en, up, load;
  logic [3:0] lv  [4];
  logic [3:0] cnt [4];
  logic [3:0] tc, ovf;

  logic [5:0] exp_q[$];
  int n_tests = 0;
  int n_fail  = 0;

  // u0 defaults, u1 MAX=9 saturate, u2 prescale 3, u3 MAX=5 wrap
  param_counter u0 (
    .clk(clk), .rst(rst), .clr(clr[0]), .en(en[0]), .up(up[0]), .load(load[0]),
    .load_val(lv[0]), .count(cnt[0]), .tc(tc[0]), .ovf(ovf[0]));

  param_counter #(.WIDTH(4), .MAX_COUNT(9), .PRESCALE(1), .SATURATE(1)) u1 (
    .clk(clk), .rst(rst), .clr(clr[1]), .en(en[1]), .up(up[1]), .load(load[1]),
    .load_val(lv[1]), .count(cnt[1]), .tc(tc[1]), .ovf(ovf[1]));

  param_counter #(.WIDTH(4), .MAX_COUNT(15), .PRESCALE(3), .SATURATE(0)) u2 (
    .clk(clk), .rst(rst), .clr(clr[2]), .en(en[2]), .up(up[2]), .load(load[2]),
    .load_val(lv[2]), .count(cnt[2]), .tc(tc[2]), .ovf(ovf[2]));

  param_counter #(.WIDTH(4), .MAX_COUNT(5), .PRESCALE(1), .SATURATE(0)) u3 (
    .clk(clk), .rst(rst), .clr(clr[3]), .en(en[3]), .up(up[3]), .load(load[3]),
    .load_val(lv[3]), .count(cnt[3]), .tc(tc[3]), .ovf(ovf[3]));

  // clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // driver / scoreboard tasks
  task automatic push(input logic [3:0] c, input logic t, input logic o);
    exp_q.push_back({c, t, o});
  endtask

  task automatic check(input int idx, input string tag);
    logic [5:0] exp_v;
    logic [5:0] obs_v;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: expected queue empty", tag);
    end else begin
      exp_v = exp_q.pop_front();
      obs_v = {cnt[idx], tc[idx], ovf[idx]};
      assert (obs_v === exp_v) else begin
        n_fail++;
        $error("FAIL %s: count/tc/ovf observed %0d/%0b/%0b expected %0d/%0b/%0b",
               tag, obs_v[5:2], obs_v[1], obs_v[0], exp_v[5:2], exp_v[1], exp_v[0]);
      end
    end
  endtask

  task automatic step_chk(input int idx, input string tag);
    @(posedge clk);
    #1;
    check(idx, tag);
  endtask

  initial begin
    rst = 1'b1;
    clr = '0; en = '0; up = '0; load = '0;
    for (int i = 0; i < 4; i++) lv[i] = '0;

    // reset state of every instance
    #12;
    for (int i = 0; i < 4; i++) begin
      push(4'd0, 1'b0, 1'b0);
      check(i, "reset");
    end
    rst = 1'b0;

    // defaults: 17 up steps, wrap at 15 -> 0 with tc and sticky ovf
    en[0] = 1'b1; up[0] = 1'b1;
    for (int i = 1; i <= 17; i++) begin
      push(4'(i % 16), (i == 16), (i >= 16));
      step_chk(0, "wrap_up");
    end
    en[0] = 1'b0;

    // saturate down at 0, then up to 9 and hold
    en[1] = 1'b1; up[1] = 1'b0;
    for (int i = 0; i < 3; i++) begin
      push(4'd0, 1'b1, 1'b1);
      step_chk(1, "sat_down");
    end
    up[1] = 1'b1;
    for (int i = 1; i <= 12; i++) begin
      push((i > 9) ? 4'd9 : 4'(i), (i > 9), 1'b1);
      step_chk(1, "sat_up");
    end
    en[1] = 1'b0;
    push(4'd9, 1'b0, 1'b1);
    step_chk(1, "sat_hold");

    // load clamping and clr-over-load
    load[1] = 1'b1; lv[1] = 4'd3;
    push(4'd3, 1'b0, 1'b1);
    step_chk(1, "load_3");
    lv[1] = 4'hE;
    push(4'd9, 1'b0, 1'b1);
    step_chk(1, "load_clamp");
    lv[1] = 4'd5; clr[1] = 1'b1;
    push(4'd0, 1'b0, 1'b0);
    step_chk(1, "clr_over_load");
    load[1] = 1'b0; clr[1] = 1'b0;

    // prescale 3: steps at edges 3 and 6
    en[2] = 1'b1; up[2] = 1'b1;
    for (int i = 1; i <= 7; i++) begin
      push(4'(i / 3), 1'b0, 1'b0);
      step_chk(2, "prescale");
    end
    // pre==1 now; pausing en keeps the phase
    en[2] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      push(4'd2, 1'b0, 1'b0);
      step_chk(2, "pre_pause");
    end
    en[2] = 1'b1;
    push(4'd2, 1'b0, 1'b0);
    step_chk(2, "pre_resume1");
    push(4'd3, 1'b0, 1'b0);
    step_chk(2, "pre_resume2");
    // direction flip mid-phase: sampled only at the step edge
    up[2] = 1'b0;
    push(4'd3, 1'b0, 1'b0);
    step_chk(2, "pre_down1");
    push(4'd3, 1'b0, 1'b0);
    step_chk(2, "pre_down2");
    push(4'd2, 1'b0, 1'b0);
    step_chk(2, "pre_down3");
    en[2] = 1'b0;

    // u0: count 1 -> 7 with ovf still set, then async reset mid-cycle
    en[0] = 1'b1;
    for (int i = 2; i <= 7; i++) begin
      push(4'(i), 1'b0, 1'b1);
      step_chk(0, "pre_rst_count");
    end
    #2;
    rst = 1'b1;
    #1;
    push(4'd0, 1'b0, 1'b0);
    check(0, "async_rst");
    @(negedge clk);
    rst = 1'b0;
    push(4'd1, 1'b0, 1'b0);
    step_chk(0, "rst_resume");
    en[0] = 1'b0;

    // MAX=5 wrap-down: load 0, then 5, 4, 3 with tc only on 0->5
    load[3] = 1'b1; lv[3] = 4'd0;
    push(4'd0, 1'b0, 1'b0);
    step_chk(3, "load_0");
    load[3] = 1'b0; en[3] = 1'b1; up[3] = 1'b0;
    push(4'd5, 1'b1, 1'b1);
    step_chk(3, "wrap_down_5");
    push(4'd4, 1'b0, 1'b1);
    step_chk(3, "wrap_down_4");
    push(4'd3, 1'b0, 1'b1);
    step_chk(3, "wrap_down_3");
    en[3] = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/param_counter.md
Name: param_counter

Overview:
- Parametrised successor to the basic free-running 4-bit counter.
- Adds configurable width and modulo limit, up/down direction, synchronous load and clear, an enable with built-in prescaler, wrap or saturate mode, a terminal-count pulse and a sticky overflow flag.
- Used as a general event/timer counter wherever a plain up-counter is insufficient.

Parameters:
- WIDTH, 4, count register width in bits (1..32).
- MAX_COUNT, 2**WIDTH-1, highest legal count value (1..2**WIDTH-1); counter range is 0..MAX_COUNT.
- PRESCALE, 1, number of enabled cycles per count step (1..65536); 1 = step every enabled cycle.
- SATURATE, 0, boundary behaviour: 0 = wrap, 1 = saturate (hold at bound).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- clr  input  1  synchronous clear of count, prescaler and ovf.
- en  input  1  count enable; feeds the prescaler.
- up  input  1  direction: 1 = increment, 0 = decrement; sampled on each step.
- load  input  1  synchronous load of load_val.
- load_val  input  WIDTH  value for load.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered, one cycle.
- ovf  output  1  sticky overflow/underflow flag, registered.

Behaviour:
- Reset (async, rst=1): count=0, tc=0, ovf=0, prescaler=0 immediately, independent of clk. Release is synchronous to the next edge; first update occurs on the first rising edge with rst=0.
- Per-edge priority: clr > load > step > hold.
- clr=1: count=0, prescaler=0, ovf=0, tc=0.
- load=1 (clr=0):
  - count = min(load_val, MAX_COUNT); prescaler=0; tc=0; ovf unchanged.
  - en is ignored that cycle.
- Prescaler:
  - Internal counter pre, width $clog2(PRESCALE) (min 1). Advances only when en=1 and no clr/load.
  - When en=1 and pre==PRESCALE-1: a step occurs and pre returns to 0; otherwise pre increments.
  - en=0 holds pre; it does not reset.
  - PRESCALE=1: step on every enabled cycle; pre is constant 0.
- Step, up=1:
  - count<MAX_COUNT: count+1.
  - count==MAX_COUNT: SATURATE=0 gives count=0; SATURATE=1 holds MAX_COUNT. Both assert tc=1 and ovf=1 on that edge.
- Step, down=1 (up=0):
  - count>0: count-1.
  - count==0: SATURATE=0 gives count=MAX_COUNT; SATURATE=1 holds 0. Both assert tc and ovf.
- tc is high for exactly the one cycle following a boundary step. Repeated boundary steps while saturated pulse tc again on each step. tc=0 on every non-boundary edge.
- ovf stays set until clr or rst. It is not cleared by load.
- All arithmetic is WIDTH bits unsigned. Boundary compares use MAX_COUNT, never natural 2**WIDTH rollover. Values above MAX_COUNT are unreachable except via rst-free illegal parameters, which are caught by elaboration assertions on the parameter ranges.
- Direction change mid-prescale: the direction is sampled only at the step edge; the prescaler phase is kept.
- Simultaneous clr and load: clr wins; count=0.

Decomposition:
- Shared package counter_pkg:
  - localparam DIR_UP=1'b1 / DIR_DOWN=1'b0.
  - localparam MODE_WRAP=0 / MODE_SAT=1.
  - Function clamp(value, max) used for load clamping.
- One sub-module, counter_prescaler:
  - Parameter PRESCALE.
  - Ports clk, rst, clr (driven by clr|load), en, step output.
  - Instantiated once.
- The count/tc/ovf datapath stays in param_counter.

Test Plan:
- Defaults (WIDTH=4, MAX_COUNT=15, PRESCALE=1, SATURATE=0), en=1, up=1 for 17 cycles after reset → count 1..15, then 0, then 1; tc high exactly the cycle count shows 0; ovf=1 thereafter.
- MAX_COUNT=9, SATURATE=1, up=0 from reset, en=1 for 3 cycles → count holds 0; tc pulses each cycle; ovf=1. Then up=1 for 12 cycles → 1..9 then holds 9; tc on each held step.
- PRESCALE=3, en=1, up=1 → count increments every 3rd edge (1 at edge 3, 2 at edge 6). Drop en for 2 cycles at pre==1, re-raise → next step after 2 more enabled edges.
- load=1, load_val=4'hE with MAX_COUNT=9 → count=9 next edge, ovf unchanged. Same edge with clr=1 → count=0, ovf=0.
- Assert rst asynchronously mid-cycle with count=7, ovf=1 → count=0, ovf=0, tc=0 before the next clk edge. Counting resumes on the first edge after release.
- Wrap-down: MAX_COUNT=5, load 0, up=0, en=1 → count 5, 4, 3; tc only on the 0→5 transition.
